// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W   = 19;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Which producer queue supplies the head popped this cycle.
  typedef enum logic {
    CH_ALU = 1'b0,
    CH_MEM = 1'b1
  } ch_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue for one producer. Each slot carries a valid bit so the
// owner can see every queued destination address.
module wb_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
  output logic [DEPTH-1:0]              entry_valid
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;
  logic [PtrW-1:0]              wr_ptr_q;
  logic [PtrW-1:0]              rd_ptr_q;
  logic                         push_ok;
  logic                         pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slots fill in order, so the queue is full/empty exactly when all/none are valid.
  always_comb begin
    full        = &valid_q;
    empty       = ~|valid_q;
    push_ok     = push && !full;
    pop_ok      = pop && !empty;
    head_addr   = addr_q[rd_ptr_q];
    head_data   = data_q[rd_ptr_q];
    entry_addr  = addr_q;
    entry_valid = valid_q;
  end

  // Storage, slot valid bits and circular pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        addr_q[wr_ptr_q]  <= push_addr;
        data_q[wr_ptr_q]  <= push_data;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      // Push is refused when full and pop needs non-empty, so the slots differ.
      if (pop_ok) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load-unit results into the single register-file write port.
// MEM has priority; a starvation counter forces an ALU win after a run of losses.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W       = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alu_valid,
  output logic                             alu_ready,
  input  logic [ADDR_W-1:0]                alu_addr,
  input  logic [DATA_W-1:0]                alu_data,
  input  logic                             mem_valid,
  output logic                             mem_ready,
  input  logic [ADDR_W-1:0]                mem_addr,
  input  logic [DATA_W-1:0]                mem_data,
  output logic                             wr_en,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [DATA_W-1:0]                wr_data,
  output logic [regfile_pkg::NUM_REGS-1:0] pending,
  output logic                             idle
);

  import regfile_pkg::*;

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic                             alu_full, alu_empty, mem_full, mem_empty;
  logic                             alu_push, mem_push, alu_pop, mem_pop, any_pop;
  logic [ADDR_W-1:0]                alu_head_addr, mem_head_addr, pop_addr;
  logic [DATA_W-1:0]                alu_head_data, mem_head_data, pop_data;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] alu_ent_addr, mem_ent_addr;
  logic [FIFO_DEPTH-1:0]            alu_ent_valid, mem_ent_valid;
  ch_sel_e                          sel;
  logic [CntW-1:0]                  starve_q, starve_d;
  logic                             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]                wr_data_q, wr_data_d;

  // Ready drops during reset so nothing is accepted while state is being cleared.
  always_comb begin
    alu_ready = !alu_full && !rst;
    mem_ready = !mem_full && !rst;
    alu_push  = alu_valid && alu_ready;
    mem_push  = mem_valid && mem_ready;
  end

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (alu_push),
    .push_addr   (alu_addr),
    .push_data   (alu_data),
    .pop         (alu_pop),
    .full        (alu_full),
    .empty       (alu_empty),
    .head_addr   (alu_head_addr),
    .head_data   (alu_head_data),
    .entry_addr  (alu_ent_addr),
    .entry_valid (alu_ent_valid)
  );

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (mem_push),
    .push_addr   (mem_addr),
    .push_data   (mem_data),
    .pop         (mem_pop),
    .full        (mem_full),
    .empty       (mem_empty),
    .head_addr   (mem_head_addr),
    .head_data   (mem_head_data),
    .entry_addr  (mem_ent_addr),
    .entry_valid (mem_ent_valid)
  );

  // Arbitration, starvation tracking and next write-port values.
  always_comb begin
    sel = CH_MEM;
    if (mem_empty || (!alu_empty && starve_q == CntW'(STARVE_LIMIT))) begin
      sel = CH_ALU;
    end
    any_pop = !alu_empty || !mem_empty;
    alu_pop = any_pop && (sel == CH_ALU);
    mem_pop = any_pop && (sel == CH_MEM);

    starve_d = starve_q;
    if (alu_empty || sel == CH_ALU) begin
      starve_d = '0;
    end else if (starve_q != CntW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end

    pop_addr = (sel == CH_ALU) ? alu_head_addr : mem_head_addr;
    pop_data = (sel == CH_ALU) ? alu_head_data : mem_head_data;

    // Register 0 is hard-wired: its writes are dropped and the port holds.
    wr_en_d   = any_pop && (pop_addr != '0);
    wr_addr_d = wr_en_d ? pop_addr : wr_addr_q;
    wr_data_d = wr_en_d ? pop_data : wr_data_q;
  end

  // Write-port and starvation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Scoreboard view: every register with a write queued or on the port.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_ent_valid[i]) pending[alu_ent_addr[i]] = 1'b1;
      if (mem_ent_valid[i]) pending[mem_ent_addr[i]] = 1'b1;
    end
    if (wr_en_q) pending[wr_addr_q] = 1'b1;
    pending[0] = 1'b0;
    wr_en   = wr_en_q;
    wr_addr = wr_addr_q;
    wr_data = wr_data_q;
    idle    = alu_empty && mem_empty && !wr_en_q;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, 19, width of write data and queued results.
REQ-002 Parameter ADDR_W, 5, register address width (32 registers).
REQ-003 Parameter FIFO_DEPTH, 2, entries per producer queue.
REQ-004 Parameter STARVE_LIMIT, 3, consecutive ALU losses before ALU is forced to win.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 alu_valid/alu_ready  input/output  1/1  ALU result handshake.
REQ-008 alu_addr/alu_data  input  ADDR_W/DATA_W  ALU destination register and result.
REQ-009 mem_valid/mem_ready  input/output  1/1  load-unit result handshake.
REQ-010 mem_addr/mem_data  input  ADDR_W/DATA_W  load destination register and data.
REQ-011 wr_en  output  1  register-file write enable, registered.
REQ-012 wr_addr/wr_data  output  ADDR_W/DATA_W  register-file write address/data, registered.
REQ-013 pending  output  32  bit i high while any queued or issuing write targets register i.
REQ-014 idle  output  1  high when both queues are empty and wr_en is low.

Function
REQ-015 Each channel SHALL own a FIFO_DEPTH-entry in-order queue; a transfer occurs on a rising edge where valid and ready are both high.
REQ-016 x_ready SHALL equal (queue not full) and (rst low); a push into a full queue is not permitted, even in a cycle where that queue pops.
REQ-017 Each cycle in which at least one queue is non-empty, exactly one head SHALL be popped and registered onto wr_addr/wr_data.
REQ-018 Arbitration: the MEM head wins by default; the ALU head wins when MEM is empty or the starvation counter equals STARVE_LIMIT.
REQ-019 Starvation counter: increments (saturating at STARVE_LIMIT) when ALU is non-empty and loses; clears when ALU wins or ALU is empty.
REQ-020 A popped entry with address 0 SHALL be discarded: wr_en stays low that cycle, wr_addr/wr_data hold their previous values.
REQ-021 wr_en SHALL be high for exactly one cycle per non-zero popped entry; with no pop, wr_en is low.
REQ-022 Latency: an entry accepted at edge k into an empty system SHALL drive wr_en high during the cycle following edge k+1.
REQ-023 Per-channel write order SHALL be preserved; across channels, only REQ-018 order applies.
REQ-024 pending SHALL be combinational OR of decoded addresses of all valid queue entries plus wr_addr when wr_en is high; bit 0 is always 0.
REQ-025 Simultaneous accept on both channels while both queues have space SHALL succeed; both entries are enqueued in the same edge.
REQ-026 A queue at full with its head popping SHALL deassert ready that cycle and reassert ready in the next cycle.

Reset
REQ-027 On rst assertion, without waiting for clk: queues empty, wr_en=0, wr_addr=0, wr_data=0, starvation counter=0, pending=0, idle=1, alu_ready=mem_ready=0.
REQ-028 Reset mid-operation SHALL discard all queued entries; no write issues for them after rst deasserts.
REQ-029 After rst deasserts, both ready outputs SHALL be high in the first cycle.

Structure
REQ-030 Shared package regfile_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS=32 and the channel-select enumeration (CH_ALU, CH_MEM).
REQ-031 The per-channel queue SHALL be one sub-module, wb_fifo (push/pop/full/empty, head, entry-address view for pending), instantiated twice.
REQ-032 Arbiter, starvation counter, output registers and pending decode SHALL live in the top module.

Verification
REQ-033 Single ALU write addr 5, data 0x12345 into idle -> wr_en high one cycle, two edges after accept, with wr_addr=5, wr_data=0x12345; pending[5] high from accept until wr_en drops.
REQ-034 Both channels valid same cycle (ALU addr 3, MEM addr 4) -> MEM write addr 4 first, ALU write addr 3 next cycle.
REQ-035 MEM held valid continuously with ALU entry queued -> ALU loses 3 cycles, wins on the 4th, counter clears.
REQ-036 Write to addr 0 with data 0x7FFFF -> no wr_en pulse, queue drains, idle returns high, wr_addr/wr_data unchanged.
REQ-037 Fill ALU queue (2 entries) with MEM busy -> alu_ready low while full; ready returns the cycle after the first ALU pop.
REQ-038 Assert rst with 3 entries queued -> wr_en, pending clear immediately; no writes after release; ready high in first post-reset cycle.
